// File: rtl/cam_pkg.sv
// Shared types for the scaled camera capture: output formats, FSM states,
// RGB565 pixel layout and the native bit width of each output format.
package cam_pkg;

  typedef enum logic [1:0] {
    MODE_RGB332 = 2'd0,
    MODE_RGB444 = 2'd1,
    MODE_GRAY8  = 2'd2,
    MODE_RGB565 = 2'd3
  } cam_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_VBLANK    = 3'd1,
    ST_WAIT_LINE = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_SKIP      = 3'd4,
    ST_END_LINE  = 3'd5,
    ST_DONE      = 3'd6
  } cam_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Bits a stored pixel occupies in a given format
  function automatic int unsigned px_width(input cam_mode_e m);
    case (m)
      MODE_RGB444: return 12;
      MODE_RGB565: return 16;
      default:     return 8;
    endcase
  endfunction

endpackage

// File: rtl/cam_px_convert.sv
// Combinational RGB565 pair -> stored pixel conversion; formats wider than
// the memory fall back to the widest format that fits.
module cam_px_convert
  import cam_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [15:0]   i_pair,
  input  logic [1:0]    i_mode,
  output logic [DW-1:0] o_data_c
);

  rgb565_t     w_px;
  cam_mode_e   w_mode;
  logic [7:0]  w_r8;
  logic [7:0]  w_g8;
  logic [7:0]  w_b8;
  logic [7:0]  w_y;
  logic [10:0] w_y_sum;
  logic [15:0] w_full;

  assign w_px = i_pair;

  always_comb begin
    w_mode = cam_mode_e'(i_mode);
    if (px_width(w_mode) > DW) begin
      w_mode = (px_width(MODE_RGB444) <= DW) ? MODE_RGB444 : MODE_RGB332;
    end
  end

  // Channels widened to 8 bits by replicating their MSBs, then weighted 2:5:1
  assign w_r8    = {w_px.r, w_px.r[4:2]};
  assign w_g8    = {w_px.g, w_px.g[5:4]};
  assign w_b8    = {w_px.b, w_px.b[4:2]};
  assign w_y_sum = (11'(w_r8) << 1) + (11'(w_g8) * 11'd5) + 11'(w_b8);
  assign w_y     = 8'(w_y_sum >> 3);

  always_comb begin
    w_full = 16'h0000;
    case (w_mode)
      MODE_RGB332: w_full = {8'h00, w_px.r[4:2], w_px.g[5:3], w_px.b[4:3]};
      MODE_RGB444: w_full = {4'h0, w_px.r[4:1], w_px.g[5:2], w_px.b[4:1]};
      MODE_GRAY8:  w_full = {8'h00, w_y};
      default:     w_full = i_pair;
    endcase
  end

  assign o_data_c = DW'(w_full);

endmodule

// File: rtl/cam_capture_scaled.sv
// Sensor-side capture of RGB565 byte pairs into frame memory with format
// conversion, decimation, clipping, short-line recovery and frame accounting.
module cam_capture_scaled
  import cam_pkg::*;
#(
  parameter int unsigned IMG_W = 176,
  parameter int unsigned IMG_H = 144,
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEC   = 1
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  input  logic [1:0]    mode,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          err,
  output logic [7:0]    frame_cnt
);

  localparam int unsigned   CW        = $clog2(IMG_W + 1);
  localparam int unsigned   RW        = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_END   = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [AW-1:0] LINE_STEP = AW'(IMG_W);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

  cam_state_e    r_state;
  cam_state_e    w_state_nxt;
  logic [1:0]    r_mode;
  logic          r_phase;
  logic [7:0]    r_hi;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_base;
  logic          r_src_col_odd;
  logic          r_src_row_odd;

  logic          w_keep_col;
  logic          w_keep_row;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_conv;

  logic          w_frame_start_c;
  logic          w_abort_c;
  logic          w_line_start_c;
  logic          w_hi_c;
  logic          w_lo_c;
  logic          w_short_c;
  logic          w_row_end_c;

  // Sensor-side parity decides which pixels and lines survive decimation
  assign w_keep_col = (DEC == 1) || !r_src_col_odd;
  assign w_keep_row = (DEC == 1) || !r_src_row_odd;
  assign w_addr     = r_base + AW'(r_col);

  cam_px_convert #(
    .DW (DW)
  ) u_convert (
    .i_pair   ({r_hi, px_data}),
    .i_mode   (r_mode),
    .o_data_c (w_conv)
  );

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus one-cycle strobes that steer the datapath registers
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_start_c = 1'b0;
    w_abort_c       = 1'b0;
    w_line_start_c  = 1'b0;
    w_hi_c          = 1'b0;
    w_lo_c          = 1'b0;
    w_short_c       = 1'b0;
    w_row_end_c     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (vsync) w_state_nxt = ST_VBLANK;
      end
      ST_VBLANK: begin
        if (!vsync) begin
          w_frame_start_c = 1'b1;
          w_state_nxt     = ST_WAIT_LINE;
        end
      end
      ST_WAIT_LINE: begin
        if (vsync) begin
          w_abort_c   = 1'b1;
          w_state_nxt = ST_VBLANK;
        end else if (href) begin
          if (w_keep_row) begin
            w_line_start_c = 1'b1;
            w_state_nxt    = ST_CAPTURE;
          end else begin
            w_state_nxt = ST_SKIP;
          end
        end
      end
      ST_CAPTURE: begin
        if (vsync) begin
          w_abort_c   = 1'b1;
          w_state_nxt = ST_VBLANK;
        end else if (!href) begin
          w_short_c   = (r_col != COL_END) || r_phase;
          w_state_nxt = ST_END_LINE;
        end else if (r_col == COL_END) begin
          w_state_nxt = ST_SKIP;
        end else if (!r_phase) begin
          w_hi_c = 1'b1;
        end else begin
          w_lo_c = 1'b1;
        end
      end
      ST_SKIP: begin
        if (vsync) begin
          w_abort_c   = 1'b1;
          w_state_nxt = ST_VBLANK;
        end else if (!href) begin
          w_state_nxt = ST_END_LINE;
        end
      end
      ST_END_LINE: begin
        if (vsync) begin
          w_abort_c   = 1'b1;
          w_state_nxt = ST_VBLANK;
        end else begin
          w_row_end_c = 1'b1;
          w_state_nxt = (w_keep_row && (r_row == ROW_LAST)) ? ST_DONE : ST_WAIT_LINE;
        end
      end
      ST_DONE: begin
        if (vsync) w_state_nxt = ST_VBLANK;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_mode        <= 2'd0;
      r_phase       <= 1'b0;
      r_hi          <= 8'h00;
      r_col         <= '0;
      r_row         <= '0;
      r_base        <= '0;
      r_src_col_odd <= 1'b0;
      r_src_row_odd <= 1'b0;
      mem_px_addr   <= '0;
      mem_px_data   <= '0;
      px_wr         <= 1'b0;
      frame_done    <= 1'b0;
      err           <= 1'b0;
      frame_cnt     <= 8'h00;
    end else begin
      px_wr      <= 1'b0;
      frame_done <= 1'b0;

      if (w_frame_start_c) begin
        r_mode        <= mode;
        err           <= 1'b0;
        r_row         <= '0;
        r_base        <= '0;
        r_src_row_odd <= 1'b0;
      end

      if (w_abort_c || w_short_c) begin
        err <= 1'b1;
      end

      if (w_line_start_c) begin
        r_hi          <= px_data;
        r_phase       <= 1'b1;
        r_col         <= '0;
        r_src_col_odd <= 1'b0;
      end

      if (w_hi_c) begin
        r_hi    <= px_data;
        r_phase <= 1'b1;
      end

      // Low byte completes a pixel; only kept pixels reach memory
      if (w_lo_c) begin
        r_phase       <= 1'b0;
        r_src_col_odd <= ~r_src_col_odd;
        if (w_keep_col) begin
          px_wr       <= 1'b1;
          mem_px_addr <= w_addr;
          mem_px_data <= w_conv;
          r_col       <= r_col + CW'(1);
          if (w_addr == LAST_ADDR) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
          end
        end
      end

      // Base advances a full line even after a short line; frozen on the last row
      if (w_row_end_c) begin
        r_src_row_odd <= ~r_src_row_odd;
        if (w_keep_row && (r_row != ROW_LAST)) begin
          r_row  <= r_row + RW'(1);
          r_base <= r_base + LINE_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_scaled.sv
// Bench: two capture instances (full-rate 16-bit, decimated 8-bit) share one
// sensor stream; a frame-level model predicts every write, err and count.
module tb_cam_capture_scaled;

  localparam int W = 4;
  localparam int H = 2;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] px_data = 8'h00;
  logic [1:0] mode = 2'd0;

  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_data;
  logic [7:0]  b_data;
  logic        a_wr, b_wr, a_fd, b_fd, a_err, b_err;
  logic [7:0]  a_cnt, b_cnt;

  cam_capture_scaled #(.IMG_W(W), .IMG_H(H), .AW(3), .DW(16), .DEC(1)) u_dut_a (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data), .mode(mode),
    .mem_px_addr(a_addr), .mem_px_data(a_data), .px_wr(a_wr), .frame_done(a_fd),
    .err(a_err), .frame_cnt(a_cnt)
  );

  cam_capture_scaled #(.IMG_W(W), .IMG_H(H), .AW(3), .DW(8), .DEC(2)) u_dut_b (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data), .mode(mode),
    .mem_px_addr(b_addr), .mem_px_data(b_data), .px_wr(b_wr), .frame_done(b_fd),
    .err(b_err), .frame_cnt(b_cnt)
  );

  always #5 pclk = ~pclk;

  int n_total = 0;
  int n_fail  = 0;

  int         ln_len [8];
  logic [7:0] ln_byte [8][20];
  logic [15:0] gray_pat [4];

  logic [18:0] cap_a[$];
  logic [18:0] cap_b[$];
  logic [18:0] exp_q[$];
  int fd_a = 0, fd_b = 0, orphan = 0;
  int snap_a, snap_b, fd_snap_a, fd_snap_b;
  int exp_cnt_a = 0, exp_cnt_b = 0;

  // Record every write and frame_done pulse between clock edges
  always @(negedge pclk) begin
    if (a_wr) cap_a.push_back({a_addr, a_data});
    if (b_wr) cap_b.push_back({b_addr, 8'h00, b_data});
    if (a_fd) begin fd_a++; if (!a_wr) orphan++; end
    if (b_fd) begin fd_b++; if (!b_wr) orphan++; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_conv(input logic [15:0] p, input int md, input int dw);
    int r5, g6, b5, m, r8, g8, b8;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    m  = md;
    if (dw == 8 && (m == 1 || m == 3)) m = 0;
    if (dw == 12 && m == 3) m = 1;
    case (m)
      0: return 16'((r5 / 4) * 32 + (g6 / 8) * 4 + (b5 / 8));
      1: return 16'((r5 / 2) * 256 + (g6 / 4) * 16 + (b5 / 2));
      2: begin
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return 16'((2 * r8 + 5 * g8 + b8) / 8);
      end
      default: return p;
    endcase
  endfunction

  // kind 0 random, 1 constant F800, 2 cycling gray patterns
  task automatic fill(input int l, input int nb, input int kind);
    logic [15:0] pr;
    ln_len[l] = nb;
    for (int b = 0; b < nb; b++) begin
      if (kind == 0) begin
        ln_byte[l][b] = 8'($urandom_range(0, 255));
      end else begin
        pr = (kind == 1) ? 16'hF800 : gray_pat[(b / 2 + l) % 4];
        ln_byte[l][b] = (b % 2 == 0) ? pr[15:8] : pr[7:0];
      end
    end
  endtask

  // Frame-level behaviour: decimate, clip, place, flag short lines and early vsync
  task automatic model(input int dec, input int dw, input int md, input int nl,
                       output int e_err, output int e_fd);
    int row, srow, col, addr;
    bit done;
    logic [15:0] pr;
    exp_q.delete();
    row = 0; srow = 0; done = 0; e_err = 0; e_fd = 0;
    for (int l = 0; l < nl; l++) begin
      if (!done) begin
        if (srow % dec == 0) begin
          col = 0;
          for (int p = 0; p < ln_len[l] / 2; p++) begin
            if (p % dec == 0 && col < W) begin
              addr = row * W + col;
              pr = {ln_byte[l][2*p], ln_byte[l][2*p+1]};
              exp_q.push_back({3'(addr), ref_conv(pr, md, dw)});
              if (addr == W * H - 1) e_fd = 1;
              col++;
            end
          end
          if (col < W || (ln_len[l] % 2) != 0) e_err = 1;
          row++;
          if (row == H) done = 1;
        end
        srow++;
      end
    end
    if (!done) e_err = 1;
  endtask

  task automatic snapshot();
    snap_a = cap_a.size(); snap_b = cap_b.size();
    fd_snap_a = fd_a; fd_snap_b = fd_b;
  endtask

  task automatic check_dut(input bit is_b, input int md, input int nl, input string fr);
    int e_err, e_fd, n_got;
    logic [18:0] got;
    string nm;
    nm = $sformatf("%s_%s", fr, is_b ? "B" : "A");
    model(is_b ? 2 : 1, is_b ? 8 : 16, md, nl, e_err, e_fd);
    n_got = is_b ? cap_b.size() - snap_b : cap_a.size() - snap_a;
    chk({nm, "_nwr"}, 32'(n_got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      got = is_b ? cap_b[snap_b + i] : cap_a[snap_a + i];
      chk($sformatf("%s_wr%0d", nm, i), 32'(got), 32'(exp_q[i]));
    end
    if (is_b) begin
      exp_cnt_b = (exp_cnt_b + e_fd) % 256;
      chk({nm, "_fd"}, 32'(fd_b - fd_snap_b), 32'(e_fd));
      chk({nm, "_err"}, 32'(b_err), 32'(e_err));
      chk({nm, "_cnt"}, 32'(b_cnt), 32'(exp_cnt_b));
    end else begin
      exp_cnt_a = (exp_cnt_a + e_fd) % 256;
      chk({nm, "_fd"}, 32'(fd_a - fd_snap_a), 32'(e_fd));
      chk({nm, "_err"}, 32'(a_err), 32'(e_err));
      chk({nm, "_cnt"}, 32'(a_cnt), 32'(exp_cnt_a));
    end
  endtask

  task automatic drive_frame(input int nl, input int md, input int md_mid);
    @(negedge pclk);
    href = 1'b0; vsync = 1'b1; mode = 2'(md);
    repeat (3) @(negedge pclk);
    vsync = 1'b0;
    repeat (3) @(negedge pclk);
    mode = 2'(md_mid);
    for (int l = 0; l < nl; l++) begin
      for (int b = 0; b < ln_len[l]; b++) begin
        href = 1'b1; px_data = ln_byte[l][b];
        @(negedge pclk);
      end
      href = 1'b0; px_data = 8'h00;
      repeat (3) @(negedge pclk);
    end
    vsync = 1'b1;
    repeat (4) @(negedge pclk);
  endtask

  task automatic run(input int nl, input int md, input int md_mid, input string fr);
    snapshot();
    drive_frame(nl, md, md_mid);
    check_dut(1'b0, md, nl, fr);
    check_dut(1'b1, md, nl, fr);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_wr"},   32'(a_wr),   32'd0);
    chk({tag, "_a_fd"},   32'(a_fd),   32'd0);
    chk({tag, "_a_err"},  32'(a_err),  32'd0);
    chk({tag, "_a_cnt"},  32'(a_cnt),  32'd0);
    chk({tag, "_a_addr"}, 32'(a_addr), 32'd0);
    chk({tag, "_a_data"}, 32'(a_data), 32'd0);
    chk({tag, "_b_wr"},   32'(b_wr),   32'd0);
    chk({tag, "_b_fd"},   32'(b_fd),   32'd0);
    chk({tag, "_b_err"},  32'(b_err),  32'd0);
    chk({tag, "_b_cnt"},  32'(b_cnt),  32'd0);
    chk({tag, "_b_addr"}, 32'(b_addr), 32'd0);
    chk({tag, "_b_data"}, 32'(b_data), 32'd0);
  endtask

  initial begin
    gray_pat[0] = 16'hFFFF; gray_pat[1] = 16'h0000;
    gray_pat[2] = 16'h07E0; gray_pat[3] = 16'hF800;

    #1 rst = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(negedge pclk);
    rst = 1'b1;

    // Solid F800 frame exactly filling the full-rate instance
    fill(0, 8, 1); fill(1, 8, 1);
    run(2, 0, 0, "solid");

    // Gray patterns over an 8x4 sensor frame
    for (int l = 0; l < 4; l++) fill(l, 16, 2);
    run(4, 2, 2, "gray");

    // Random 8x4 frame in RGB565 (falls back to RGB332 on the 8-bit instance)
    for (int l = 0; l < 4; l++) fill(l, 16, 0);
    run(4, 3, 3, "rgb565");

    // Short first line, then a full line
    fill(0, 4, 0); fill(1, 8, 0);
    run(2, 1, 1, "short");

    // Odd-byte lines interleaved with long lines
    fill(0, 3, 0); fill(1, 16, 0); fill(2, 3, 0); fill(3, 16, 0);
    run(4, 1, 1, "oddbyte");

    // Over-long line followed by an early vsync
    fill(0, 12, 0);
    run(1, 0, 0, "early");

    // Clean frame clears the sticky error
    for (int l = 0; l < 4; l++) fill(l, 16, 0);
    run(4, 1, 1, "clean");

    // Async reset right after a pixel write in mid-line
    for (int l = 0; l < 4; l++) fill(l, 16, 0);
    @(negedge pclk);
    vsync = 1'b1; mode = 2'd0;
    repeat (3) @(negedge pclk);
    vsync = 1'b0;
    repeat (3) @(negedge pclk);
    for (int b = 0; b < 4; b++) begin
      href = 1'b1; px_data = ln_byte[0][b];
      @(negedge pclk);
    end
    #1 rst = 1'b0;
    #1 chk_zero("midrst");
    @(negedge pclk);
    href = 1'b0;
    repeat (2) @(negedge pclk);
    rst = 1'b1;
    exp_cnt_a = 0; exp_cnt_b = 0;

    // Mode changes after the vsync fall must not affect this frame
    for (int l = 0; l < 4; l++) fill(l, 16, 0);
    run(4, 0, 2, "postrst");

    chk("fd_orphan", 32'(orphan), 32'd0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
